cf_sram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for one CF_SRAM_1024x32 macro. It shares the macro between two independent word-access ports, such as a CPU data bus and a DMA engine, using round-robin arbitration with a valid/ready request handshake and fixed one-cycle read responses. After reset it can optionally clear the whole array before accepting traffic. It sits directly between the SoC bus adapters and the macro instance; the macro's static pins (WLBI, WLOFF, SM, TM, ScanIn*, vpwr*) are tied off at the instantiating level.

---
 rtl/cf_sram_arbiter_pkg.sv | 25 ++
 rtl/cf_sram_arbiter_if.sv | 21 ++
 rtl/cf_sram_arbiter_rr2.sv | 36 +++
 rtl/cf_sram.sv | 122 ++++++++++++
 tb/tb_cf_sram_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cf_sram_arbiter_pkg.sv
// cf_sram_pkg: shared types and helpers for the CF_SRAM_1024x32 arbiter.
//   CF_SRAM_AW / CF_SRAM_DW : macro address / data widths
//   state_t                 : top-level sequencer states
//   be_to_ben()             : byte enables -> macro bit-level write mask
package cf_sram_pkg;

  localparam int CF_SRAM_AW = 10;
  localparam int CF_SRAM_DW = 32;

  typedef enum logic [1:0] {
    BOOT,
    CLEAR,
    RUN
  } state_t;

  function automatic logic [CF_SRAM_DW-1:0] be_to_ben(input logic [3:0] be);
    logic [CF_SRAM_DW-1:0] ben;
    ben = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      ben[8*k +: 8] = {8{be[k]}};
    end
    return ben;
  endfunction

endpackage

// File: rtl/cf_sram_arbiter_if.sv
// cf_sram_arbiter_if: one word-access requester port of the SRAM arbiter.
//   valid/ready : request handshake (ready is combinational from valid)
//   we, addr, be, wdata : request fields (be used on writes only)
//   rvalid/rdata : read response, one cycle after acceptance, no backpressure
//   master = requester side, slave = arbiter side
interface cf_sram_arbiter_if;
  import cf_sram_pkg::*;

  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [CF_SRAM_AW-1:0] addr;
  logic [3:0]            be;
  logic [CF_SRAM_DW-1:0] wdata;
  logic                  rvalid;
  logic [CF_SRAM_DW-1:0] rdata;

  modport master (output valid, we, addr, be, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, be, wdata, output ready, rvalid, rdata);

endinterface

// File: rtl/cf_sram_arbiter_rr2.sv
// cf_sram_rr2: two-way round-robin grant.
//   clk, rst  : clock, asynchronous active-high reset
//   req[1:0]  : request valids (bit n = port n)
//   accept    : the granted request was taken this cycle
//   gnt_valid : some request is present
//   gnt_idx   : index of the winning port
// last_grant resets to 1 so port 0 wins the first tie; it only moves on accept.
module cf_sram_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_grant;

  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt_idx = ~last_grant;
    end else begin
      gnt_idx = req[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= gnt_idx;
    end
  end

endmodule

// File: rtl/cf_sram.sv
// cf_sram_arbiter: two-port round-robin arbiter/sequencer for CF_SRAM_1024x32.
//   CLKin, rst   : clock shared with the macro, asynchronous active-high reset
//   p0, p1       : requester ports (cf_sram_arbiter_if.slave)
//   sram_en, sram_r_wb, sram_ad, sram_ben, sram_di : macro inputs
//   sram_do      : macro read data
//   init_done    : array cleared (if enabled), requests now served
// After reset: BOOT for one cycle, optional CLEAR of all words, then RUN.
module cf_sram_arbiter
  import cf_sram_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int NWORDS         = 1024
) (
  input  logic                  CLKin,
  input  logic                  rst,
  cf_sram_arbiter_if.slave      p0,
  cf_sram_arbiter_if.slave      p1,
  output logic                  sram_en,
  output logic                  sram_r_wb,
  output logic [CF_SRAM_AW-1:0] sram_ad,
  output logic [CF_SRAM_DW-1:0] sram_ben,
  output logic [CF_SRAM_DW-1:0] sram_di,
  input  logic [CF_SRAM_DW-1:0] sram_do,
  output logic                  init_done
);

  localparam logic [CF_SRAM_AW-1:0] LAST_WORD = CF_SRAM_AW'(NWORDS - 1);

  state_t                state, state_nxt;
  logic [CF_SRAM_AW-1:0] clr_cnt, clr_nxt;
  logic                  rd_pend, rd_port;
  logic                  gnt_valid, gnt_idx, accept;

  logic                  sel_we;
  logic [CF_SRAM_AW-1:0] sel_addr;
  logic [3:0]            sel_be;
  logic [CF_SRAM_DW-1:0] sel_wdata;

  cf_sram_rr2 u_rr2 (
    .clk       (CLKin),
    .rst       (rst),
    .req       ({p1.valid, p0.valid}),
    .accept    (accept),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign sel_we    = gnt_idx ? p1.we    : p0.we;
  assign sel_addr  = gnt_idx ? p1.addr  : p0.addr;
  assign sel_be    = gnt_idx ? p1.be    : p0.be;
  assign sel_wdata = gnt_idx ? p1.wdata : p0.wdata;

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_cnt;
    accept    = 1'b0;
    sram_en   = 1'b0;
    sram_r_wb = 1'b0;
    sram_ad   = '0;
    sram_ben  = '0;
    sram_di   = '0;
    p0.ready  = 1'b0;
    p1.ready  = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = CLEAR_ON_RESET ? CLEAR : RUN;
      end
      CLEAR: begin
        sram_en   = 1'b1;
        sram_r_wb = 1'b0;
        sram_ad   = clr_cnt;
        sram_ben  = '1;
        sram_di   = '0;
        clr_nxt   = clr_cnt + 1'b1;
        if (clr_cnt == LAST_WORD) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (gnt_valid) begin
          accept    = 1'b1;
          p0.ready  = ~gnt_idx;
          p1.ready  = gnt_idx;
          sram_en   = 1'b1;
          sram_r_wb = ~sel_we;
          sram_ad   = sel_addr;
          sram_di   = sel_wdata;
          // BEN is ignored by the macro on reads; all ones keeps it well defined.
          sram_ben  = sel_we ? be_to_ben(sel_be) : '1;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge CLKin or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      clr_cnt <= '0;
      rd_pend <= 1'b0;
      rd_port <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_nxt;
      rd_pend <= accept & ~sel_we;
      if (accept) begin
        rd_port <= gnt_idx;
      end
    end
  end

  // The macro presents DO in the cycle after a read; it is shared by both ports
  // and only qualified by the per-port rvalid.
  assign p0.rvalid = rd_pend & ~rd_port;
  assign p1.rvalid = rd_pend & rd_port;
  assign p0.rdata  = sram_do;
  assign p1.rdata  = sram_do;
  assign init_done = (state == RUN);

endmodule

// File: tb/tb_cf_sram_arbiter.sv
// Scoreboard bench for cf_sram_arbiter: DUT "a" with CLEAR_ON_RESET=1, DUT "b"
// with CLEAR_ON_RESET=0, each attached to a behavioural CF_SRAM model.
module tb_cf_sram_arbiter;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  cf_sram_arbiter_if a0 ();
  cf_sram_arbiter_if a1 ();
  cf_sram_arbiter_if b0 ();
  cf_sram_arbiter_if b1 ();

  logic        a_en, a_r_wb, a_done, b_en, b_r_wb, b_done;
  logic [9:0]  a_ad, b_ad;
  logic [31:0] a_ben, a_di, a_do, b_ben, b_di, b_do;

  cf_sram_arbiter #(.CLEAR_ON_RESET(1'b1), .NWORDS(1024)) dut_a (
    .CLKin(clk), .rst(rst_a), .p0(a0), .p1(a1),
    .sram_en(a_en), .sram_r_wb(a_r_wb), .sram_ad(a_ad), .sram_ben(a_ben),
    .sram_di(a_di), .sram_do(a_do), .init_done(a_done));

  cf_sram_arbiter #(.CLEAR_ON_RESET(1'b0), .NWORDS(1024)) dut_b (
    .CLKin(clk), .rst(rst_b), .p0(b0), .p1(b1),
    .sram_en(b_en), .sram_r_wb(b_r_wb), .sram_ad(b_ad), .sram_ben(b_ben),
    .sram_di(b_di), .sram_do(b_do), .init_done(b_done));

  // Behavioural macros: BEN bit = 1 writes that bit; DO registered on reads.
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  int          wr_cnt_b = 0;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = pat(i);
      mem_b[i] = pat(i);
    end
  end

  always @(posedge clk) begin
    if (a_en) begin
      if (!a_r_wb) mem_a[a_ad] <= (mem_a[a_ad] & ~a_ben) | (a_di & a_ben);
      else         a_do <= mem_a[a_ad];
    end
    if (b_en) begin
      if (!b_r_wb) begin
        mem_b[b_ad] <= (mem_b[b_ad] & ~b_ben) | (b_di & b_ben);
        wr_cnt_b    <= wr_cnt_b + 1;
      end else begin
        b_do <= mem_b[b_ad];
      end
    end
  end

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q [4][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every rvalid pops the oldest expected word for that port.
  task automatic mon(input int idx, input logic rv, input logic [31:0] rd);
    logic [31:0] e;
    if (rv === 1'b1) begin
      if (exp_q[idx].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected port%0d: got rvalid=1 data %h expected rvalid=0", idx, rd);
      end else begin
        e = exp_q[idx].pop_front();
        chk($sformatf("rsp_data port%0d", idx), rd, e);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a0.rvalid, a0.rdata);
    mon(1, a1.rvalid, a1.rdata);
    mon(2, b0.rvalid, b0.rdata);
    mon(3, b1.rvalid, b1.rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int p, input logic v, input logic we, input logic [9:0] ad,
                     input logic [3:0] be, input logic [31:0] wd);
    case (p)
      0: begin a0.valid = v; a0.we = we; a0.addr = ad; a0.be = be; a0.wdata = wd; end
      1: begin a1.valid = v; a1.we = we; a1.addr = ad; a1.be = be; a1.wdata = wd; end
      2: begin b0.valid = v; b0.we = we; b0.addr = ad; b0.be = be; b0.wdata = wd; end
      default: begin b1.valid = v; b1.we = we; b1.addr = ad; b1.be = be; b1.wdata = wd; end
    endcase
  endtask

  // Called just after reset release on DUT a. Cycle 0 is BOOT, cycles 1..ncyc
  // are CLEAR with sram_ad = cycle-1; a full run ends on the first RUN cycle.
  task automatic clear_check(input int ncyc);
    drv(0, 1'b1, 1'b0, 10'd0, 4'h0, 32'h0);
    drv(1, 1'b1, 1'b0, 10'd0, 4'h0, 32'h0);
    @(negedge clk);
    chk("boot_ctl", {a_en, a0.ready, a1.ready, a_done}, 4'b0000);
    for (int c = 1; c <= ncyc; c++) begin
      step();
      if (c == 1024) begin
        drv(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
      end
      @(negedge clk);
      chk($sformatf("clear_ad c%0d", c), a_ad, 32'(c - 1));
      chk("clear_ctl", {a_en, a_r_wb, a0.ready, a1.ready, a_done}, 5'b10000);
      chk("clear_ben", a_ben, 32'hFFFF_FFFF);
      chk("clear_di", a_di, 32'h0);
    end
    if (ncyc == 1024) begin
      step();
      @(negedge clk);
      chk("init_done_1025", a_done, 1'b1);
      chk("run_idle_en", a_en, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [9:0]  solo_ad [8] = '{10'd2, 10'd1, 10'd5, 10'd2, 10'd1023, 10'd0, 10'd1, 10'd2};
  logic [31:0] solo_dt [8] = '{32'h22, 32'h11, 32'h00AD00EF, 32'h22, 32'h0, 32'h0, 32'h11, 32'h22};

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int p = 0; p < 4; p++) drv(p, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {a_en, a_done, a0.rvalid, a1.rvalid, a0.ready}, 5'b00000);

    // Full clear after reset release.
    step();
    rst_a = 1'b0;
    clear_check(1024);

    // Masked write then immediate read of the same word.
    step(); drv(0, 1'b1, 1'b1, 10'd5, 4'b0101, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_ready", {a0.ready, a1.ready}, 2'b10);
    chk("wr_ctl", {a_en, a_r_wb}, 2'b10);
    chk("wr_ad", a_ad, 32'd5);
    chk("wr_ben", a_ben, 32'h00FF00FF);
    chk("wr_di", a_di, 32'hDEADBEEF);
    step(); drv(0, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0);
    @(negedge clk);
    chk("rd_ready", a0.ready, 1'b1);
    chk("rd_ctl", {a_en, a_r_wb}, 2'b11);
    chk("rd_ben", a_ben, 32'hFFFF_FFFF);
    exp_q[0].push_back(32'h00AD00EF);
    // Write with no byte enables: accepted, changes nothing.
    step(); drv(0, 1'b1, 1'b1, 10'd5, 4'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("be0_ready", a0.ready, 1'b1);
    chk("be0_ben", a_ben, 32'h0);
    chk("p1_no_rvalid", a1.rvalid, 1'b0);
    step(); drv(0, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0);
    @(negedge clk);
    exp_q[0].push_back(32'h00AD00EF);

    // Preload: p0 -> addr 1, p1 -> addr 2 (last_grant ends at 1).
    step(); drv(0, 1'b1, 1'b1, 10'd1, 4'hF, 32'h11);
    @(negedge clk);
    chk("pre0_ready", {a0.ready, a1.ready}, 2'b10);
    step(); drv(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0); drv(1, 1'b1, 1'b1, 10'd2, 4'hF, 32'h22);
    @(negedge clk);
    chk("pre1_ready", {a0.ready, a1.ready}, 2'b01);

    // Both ports continuously reading: strict alternation starting with p0.
    step();
    drv(0, 1'b1, 1'b0, 10'd1, 4'h0, 32'h0);
    drv(1, 1'b1, 1'b0, 10'd2, 4'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) step();
      @(negedge clk);
      chk($sformatf("alt_grant %0d", i), {a0.ready, a1.ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk($sformatf("alt_ad %0d", i), a_ad, (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i % 2 == 0) exp_q[0].push_back(32'h11);
      else            exp_q[1].push_back(32'h22);
    end

    // p1 alone for 8 cycles: accepted every cycle.
    step(); drv(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) step();
      drv(1, 1'b1, 1'b0, solo_ad[i], 4'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("solo_ready %0d", i), {a0.ready, a1.ready}, 2'b01);
      exp_q[1].push_back(solo_dt[i]);
    end

    // Idle cycles must not move last_grant: next tie goes to p0.
    step(); drv(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    step();
    step();
    drv(0, 1'b1, 1'b0, 10'd1, 4'h0, 32'h0);
    drv(1, 1'b1, 1'b0, 10'd2, 4'h0, 32'h0);
    @(negedge clk);
    chk("tie_after_idle", {a0.ready, a1.ready}, 2'b10);
    exp_q[0].push_back(32'h11);
    step(); drv(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    @(negedge clk);
    chk("tie_second", {a0.ready, a1.ready}, 2'b10);
    exp_q[0].push_back(32'h11);

    // Reset right after a read is accepted: the response is dropped.
    step(); drv(0, 1'b1, 1'b0, 10'd2, 4'h0, 32'h0);
    @(negedge clk);
    chk("abort_rd_ready", a0.ready, 1'b1);
    step();
    rst_a = 1'b1;
    drv(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    @(negedge clk);
    chk("abort_rvalid", {a0.rvalid, a1.rvalid, a_done, a_en}, 4'b0000);
    step();
    rst_a = 1'b0;

    // Reset during CLEAR at counter 300, then a full clear from word 0.
    clear_check(301);
    rst_a = 1'b1;
    #1;
    chk("midclear_rst", {a_en, a_done}, 2'b00);
    step();
    rst_a = 1'b0;
    clear_check(1024);
    step(); drv(0, 1'b1, 1'b0, 10'd1, 4'h0, 32'h0);
    @(negedge clk);
    chk("post_clear_rd_ready", a0.ready, 1'b1);
    exp_q[0].push_back(32'h0);
    step(); drv(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    @(negedge clk);

    // DUT b: no clear, serving from cycle 1, original contents visible.
    drv(2, 1'b1, 1'b0, 10'h3A7, 4'h0, 32'h0);
    step();
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_boot", {b_en, b0.ready, b1.ready, b_done}, 4'b0000);
    step();
    @(negedge clk);
    chk("b_init_done", b_done, 1'b1);
    chk("b_ready", b0.ready, 1'b1);
    chk("b_ad", b_ad, 32'h3A7);
    chk("b_no_clear_writes", wr_cnt_b, 32'd0);
    exp_q[2].push_back(pat(32'h3A7));
    step(); drv(2, 1'b1, 1'b0, 10'd1023, 4'h0, 32'h0);
    @(negedge clk);
    exp_q[2].push_back(pat(1023));
    step(); drv(2, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    step();
    @(negedge clk);

    for (int p = 0; p < 4; p++) chk($sformatf("queue_empty port%0d", p), exp_q[p].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
